dmem_responder: RTL

- Memory-side responder for the pipeline's data-memory port: accepts one load/store request at a time from the MEM stage, holds it for a programmable latency, then returns one response.
- Lets the pipeline and its bench exercise stall/handshake paths instead of a zero-latency combinational memory.
- Sits between the mips top level's MEM stage (initiator) and a word-organised storage array inside this block.

---
 rtl/dmem_responder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the pipeline's data-memory port. Accepts one
// load/store at a time, holds it for LATENCY cycles and then returns a single
// one-cycle response. The word-organised storage array lives inside this block
// and is touched exactly once per transaction, on the edge entering RESP.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous, active-low reset
//   req_valid   request present
//   req_write   1 = store, 0 = load
//   req_addr    byte address
//   req_wdata   store data, lane-aligned
//   req_be      store byte enables (bit i -> bits [8i+7:8i])
//   req_ready   block can accept a request this cycle (IDLE)
//   resp_valid  one-cycle response strobe (RESP)
//   resp_rdata  load data; 0 for stores and errors; holds until next response
//   resp_err    request rejected; meaningful only with resp_valid
//   busy        request in flight (WAIT or RESP)
//   fsm_state   current FSM state, for debug/checkers (0 IDLE, 1 WAIT, 2 RESP)
//
// Handshake: a request is accepted on the rising edge where req_valid and
// req_ready are both 1; the request fields are captured on that edge and
// ignored afterwards until the block is back in IDLE. resp_valid is high in
// the LATENCY-th cycle after the cycle in which the request was presented.
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic [1:0]  fsm_state
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic [3:0] cnt;
    logic       accept;
    logic       enter_resp;

    // Captured request
    logic        l_write;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [3:0]  l_be;

    // Operands used for the single array access
    logic                  a_write;
    logic [31:0]           a_addr;
    logic [31:0]           a_wdata;
    logic [3:0]            a_be;
    logic                  a_err;
    logic [ADDR_WIDTH-1:0] a_idx;
    logic                  commit;

    logic [31:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    next_state = S_RESP;
                end
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign req_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign fsm_state  = state;
    assign enter_resp = (next_state == S_RESP) && (state != S_RESP);

    // ------------------------------------------------------------------
    // State, counter and request capture
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            l_write <= 1'b0;
            l_addr  <= 32'd0;
            l_wdata <= 32'd0;
            l_be    <= 4'd0;
        end else begin
            state <= next_state;
            if (accept) begin
                cnt     <= 4'(LATENCY - 1);
                l_write <= req_write;
                l_addr  <= req_addr;
                l_wdata <= req_wdata;
                l_be    <= req_be;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // With LATENCY=1 the access happens on the accepting edge itself, before
    // the captured copy exists, so the live request fields are used in IDLE.
    always_comb begin
        if (state == S_IDLE) begin
            a_write = req_write;
            a_addr  = req_addr;
            a_wdata = req_wdata;
            a_be    = req_be;
        end else begin
            a_write = l_write;
            a_addr  = l_addr;
            a_wdata = l_wdata;
            a_be    = l_be;
        end
    end

    assign a_err = (a_addr[1:0] != 2'b00) || (a_addr[31:ADDR_WIDTH+2] != '0);
    assign a_idx = a_addr[ADDR_WIDTH+1:2];
    // reset gating keeps an aborted transaction from ever writing
    assign commit = enter_resp && a_write && !a_err && reset;

    // ------------------------------------------------------------------
    // Storage array (not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (a_be[b]) begin
                    mem[a_idx][8*b +: 8] <= a_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            resp_err <= enter_resp && a_err;
            if (enter_resp) begin
                resp_rdata <= (a_write || a_err) ? 32'd0 : mem[a_idx];
            end
        end
    end

endmodule
